// File: rtl/scan_pkg.sv
// Shared types and constants for the channel scanner.
package scan_pkg;

   // Scanner FSM states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   localparam int NUM_CH    = 4;
   localparam int DWELL_DEF = 4;

   // Lowest enabled channel in a mask (0 when the mask is empty).
   function automatic logic [1:0] first_chan(input logic [NUM_CH-1:0] mask);
      logic [1:0] w_lo;
      w_lo = 2'd0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (mask[c]) w_lo = 2'(c);
      end
      return w_lo;
   endfunction

endpackage

// File: rtl/scan_next_chan.sv
// Next enabled channel above the current one, wrapping to the lowest
// enabled channel (with o_wrap set) when none is left above.
module scan_next_chan
   import scan_pkg::*;
(
   input  logic [1:0]        i_chan,
   input  logic [NUM_CH-1:0] i_mask,
   output logic [1:0]        o_next,
   output logic              o_wrap
);

   // Scan downwards so the lowest enabled channel above i_chan wins.
   always_comb begin
      o_next = first_chan(i_mask);
      o_wrap = 1'b1;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (c > int'(i_chan) && i_mask[c]) begin
            o_next = 2'(c);
            o_wrap = 1'b0;
         end
      end
   end

endmodule

// File: rtl/channel_scanner.sv
// Sweeps the enabled inputs of an external 4:1 selector, lets each one
// settle for DWELL cycles and captures the selector output.
module channel_scanner
   import scan_pkg::*;
#(
   parameter int DWELL = DWELL_DEF,
   parameter int WIDTH = 4
)(
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iStart,
   input  logic             iStop,
   input  logic             iMode,
   input  logic [3:0]       iMask,
   input  logic [WIDTH-1:0] iZ,
   output logic             oS0,
   output logic             oS1,
   output logic [WIDTH-1:0] oData,
   output logic [1:0]       oChan,
   output logic             oValid,
   output logic             oBusy,
   output logic             oDone
);

   localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

   state_t             r_state;
   logic [7:0]         r_cnt;
   logic [NUM_CH-1:0]  r_mask;
   logic               r_mode;
   logic [1:0]         r_chan;
   logic [WIDTH-1:0]   r_data;
   logic [1:0]         r_ochan;
   logic               r_valid;
   logic               r_done;
   logic [1:0]         w_next;
   logic               w_wrap;

   scan_next_chan u_next (
      .i_chan (r_chan),
      .i_mask (r_mask),
      .o_next (w_next),
      .o_wrap (w_wrap)
   );

   // Sweep FSM: settle timing, capture, channel advance and stop/abort.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_mask  <= '0;
         r_mode  <= 1'b0;
         r_chan  <= 2'd0;
         r_data  <= '0;
         r_ochan <= 2'd0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (iStart && (iMask != '0) && !iStop) begin
                  r_state <= SETTLE;
                  r_mask  <= iMask;
                  r_mode  <= iMode;
                  r_chan  <= first_chan(iMask);
                  r_cnt   <= '0;
               end
            end
            SETTLE: begin
               if (iStop) begin
                  r_state <= IDLE;
               end else if (r_cnt == CNT_LAST) begin
                  r_data  <= iZ;
                  r_ochan <= r_chan;
                  r_valid <= 1'b1;
                  r_state <= CAPTURE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            CAPTURE: begin
               if (iStop) begin
                  r_state <= IDLE;
               end else if (w_wrap && !r_mode) begin
                  // Single sweep finished: keep the last channel selected.
                  r_state <= IDLE;
                  r_done  <= 1'b1;
               end else begin
                  r_chan  <= w_next;
                  r_cnt   <= '0;
                  r_state <= SETTLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign oS0    = r_chan[0];
   assign oS1    = r_chan[1];
   assign oData  = r_data;
   assign oChan  = r_ochan;
   assign oValid = r_valid;
   assign oDone  = r_done;
   assign oBusy  = (r_state != IDLE);

endmodule

// File: tb/tb_channel_scanner.sv
// Scoreboard bench for channel_scanner: a sweep-level model predicts every
// oValid/oDone event (edge number, channel, data); a monitor checks them.
module tb_channel_scanner;

   localparam int DW = 4;

   typedef struct {
      int         edge_n;
      bit         done;
      logic [1:0] ch;
      logic [3:0] data;
   } ev_t;

   logic       iClk = 1'b0;
   logic       iRst = 1'b0;
   logic       iStart = 1'b0;
   logic       iStop = 1'b0;
   logic       iMode = 1'b0;
   logic [3:0] iMask = 4'd0;
   logic [3:0] iZ;
   logic       oS0, oS1, oValid, oBusy, oDone;
   logic [3:0] oData;
   logic [1:0] oChan;

   logic [3:0] sel_data [4];
   ev_t        exp_q [$];
   int         ecount = 0;
   int         errors = 0;
   int         checks = 0;
   bit         mon_en = 1'b1;

   channel_scanner #(.DWELL(DW), .WIDTH(4)) dut (
      .iClk   (iClk),
      .iRst   (iRst),
      .iStart (iStart),
      .iStop  (iStop),
      .iMode  (iMode),
      .iMask  (iMask),
      .iZ     (iZ),
      .oS0    (oS0),
      .oS1    (oS1),
      .oData  (oData),
      .oChan  (oChan),
      .oValid (oValid),
      .oBusy  (oBusy),
      .oDone  (oDone)
   );

   // External 4:1 selector model.
   assign iZ = sel_data[{oS1, oS0}];

   always #5 iClk = ~iClk;

   always @(posedge iClk) ecount <= ecount + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d, required %0d", name, ecount, act, req);
      end
   endtask

   task automatic check_ev(input bit is_done);
      ev_t ev;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s at edge %0d: got ch=%0d data=%0h, required no event",
                  is_done ? "done" : "valid", ecount, oChan, oData);
         return;
      end
      ev = exp_q.pop_front();
      if (ev.done != is_done || ev.edge_n != ecount ||
          (!is_done && (ev.ch != oChan || ev.data != oData))) begin
         errors++;
         $display("FAIL event: got %s edge=%0d ch=%0d data=%0h, required %s edge=%0d ch=%0d data=%0h",
                  is_done ? "done" : "valid", ecount, oChan, oData,
                  ev.done ? "done" : "valid", ev.edge_n, ev.ch, ev.data);
      end
   endtask

   task automatic monitor_loop();
      forever begin
         @(negedge iClk);
         if (mon_en && !iRst) begin
            if (oValid) check_ev(1'b0);
            if (oDone)  check_ev(1'b1);
         end
      end
   endtask

   // One sweep request: predicts events, drives stimulus, checks busy/select.
   task automatic run_sweep(input logic [3:0] mask, input logic mode,
                            input int stop_in, input bit do_glitch);
      logic [1:0] lst [$];
      ev_t        ev;
      int         k, m, s, endo, e, stop_off, glitch_off;
      bit         have_cap;
      logic [1:0] last_ch;
      logic [3:0] last_d;
      stop_off = stop_in;
      have_cap = 1'b0;
      last_ch  = 2'd0;
      last_d   = 4'd0;
      for (int c = 0; c < 4; c++) if (mask[c]) lst.push_back(2'(c));
      m = lst.size();
      if (mode && m > 0 && stop_off == 0) stop_off = 3 * m * (DW + 1) + 2;
      @(negedge iClk);
      iStart = 1'b1; iMask = mask; iMode = mode; iStop = 1'b0;
      k = ecount + 1;
      s = (stop_off > 0) ? k + stop_off : 32'h7fffffff;
      if (m == 0) endo = 0;
      else if (mode) endo = stop_off;
      else if (stop_off > 0 && stop_off <= m * (DW + 1)) endo = stop_off;
      else endo = m * (DW + 1);
      if (m > 0) begin
         for (int n = 0; ; n++) begin
            e = k + DW + n * (DW + 1);
            if (e >= s || (!mode && n >= m)) break;
            ev.edge_n = e; ev.done = 1'b0;
            ev.ch = lst[n % m]; ev.data = sel_data[lst[n % m]];
            exp_q.push_back(ev);
            have_cap = 1'b1; last_ch = ev.ch; last_d = ev.data;
         end
         if (!mode && k + m * (DW + 1) < s) begin
            ev.edge_n = k + m * (DW + 1); ev.done = 1'b1; ev.ch = 2'd0; ev.data = 4'd0;
            exp_q.push_back(ev);
         end
      end
      glitch_off = (do_glitch && endo > 1) ? $urandom_range(1, endo - 1) : -1;
      for (int i = 1; i <= endo + 3; i++) begin
         @(negedge iClk);
         chk("busy", int'(oBusy), int'((i - 1) < endo));
         if ((i - 1) < endo) chk("sel_enabled", int'(mask[{oS1, oS0}]), 1);
         iStart = 1'b0; iStop = 1'b0;
         if (i == glitch_off) begin
            iStart = 1'b1; iMask = 4'($urandom); iMode = ~mode;
         end
         if (i == stop_off) iStop = 1'b1;
      end
      @(negedge iClk);
      iStart = 1'b0; iStop = 1'b0;
      if (have_cap) begin
         chk("hold_data", int'(oData), int'(last_d));
         chk("hold_chan", int'(oChan), int'(last_ch));
      end
      if (!mode && m > 0 && stop_off == 0) chk("hold_sel", int'({oS1, oS0}), int'(lst[m-1]));
   endtask

   initial begin
      int seen, m, stp;
      logic [3:0] mk;
      logic md;
      fork monitor_loop(); join_none
      for (int c = 0; c < 4; c++) sel_data[c] = 4'd0;
      // Reset state
      #1 iRst = 1'b1;
      #1;
      chk("rst_valid", int'(oValid), 0);
      chk("rst_busy",  int'(oBusy), 0);
      chk("rst_done",  int'(oDone), 0);
      chk("rst_data",  int'(oData), 0);
      chk("rst_chan",  int'(oChan), 0);
      chk("rst_sel",   int'({oS1, oS0}), 0);
      @(negedge iClk); @(negedge iClk);
      iRst = 1'b0;
      repeat (2) @(negedge iClk);

      // Full single sweep with one-hot data
      sel_data[0] = 4'b0001; sel_data[1] = 4'b0010;
      sel_data[2] = 4'b0100; sel_data[3] = 4'b1000;
      run_sweep(4'b1111, 1'b0, 0, 1'b0);
      // Sparse mask, single
      run_sweep(4'b1010, 1'b0, 0, 1'b0);
      // Continuous 0,3,0,3 then stop mid-settle
      run_sweep(4'b1001, 1'b1, 4 * (DW + 1) + 2, 1'b0);
      // Empty mask, both modes
      run_sweep(4'b0000, 1'b0, 0, 1'b0);
      run_sweep(4'b0000, 1'b1, 0, 1'b0);
      // Start/mask/mode changes while busy
      run_sweep(4'b1111, 1'b0, 0, 1'b1);
      // Single channel, both modes
      run_sweep(4'b0100, 1'b0, 0, 1'b0);
      run_sweep(4'b0100, 1'b1, 3 * (DW + 1) + 1, 1'b0);

      // Randomized sweeps
      for (int t = 0; t < 14; t++) begin
         for (int c = 0; c < 4; c++) sel_data[c] = 4'($urandom);
         mk = 4'($urandom_range(0, 15));
         md = 1'($urandom_range(0, 1));
         m  = $countones(mk);
         if (md) stp = $urandom_range(1, 40);
         else if (m > 0 && $urandom_range(0, 2) == 0) stp = $urandom_range(1, m * (DW + 1) + 2);
         else stp = 0;
         run_sweep(mk, md, stp, 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset during CAPTURE
      mon_en = 1'b0;
      @(negedge iClk);
      iStart = 1'b1; iMask = 4'b1111; iMode = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
      seen = 0;
      for (int i = 0; i < 50 && seen == 0; i++) begin
         if (oValid) seen = 1;
         else @(negedge iClk);
      end
      chk("capture_reached", seen, 1);
      #2 iRst = 1'b1;
      #1;
      chk("arst_valid", int'(oValid), 0);
      chk("arst_busy",  int'(oBusy), 0);
      chk("arst_done",  int'(oDone), 0);
      chk("arst_data",  int'(oData), 0);
      chk("arst_chan",  int'(oChan), 0);
      chk("arst_sel",   int'({oS1, oS0}), 0);
      exp_q.delete();
      @(negedge iClk);
      iRst = 1'b0;
      mon_en = 1'b1;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge iClk);
         if (oValid || oDone || oBusy) seen++;
      end
      chk("quiet_after_reset", seen, 0);

      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/channel_scanner.md
CHANNEL_SCANNER -- requirements
Module: channel_scanner

Interface
REQ-001 Parameter DWELL, default 4, SHALL set the settle cycles per channel before capture (legal range 1..255).
REQ-002 Parameter WIDTH, default 4, SHALL set the data width of iZ and oData.
REQ-003 iClk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 iRst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 iStart  input  1  SHALL be a sweep request, sampled only in IDLE.
REQ-006 iStop  input  1  SHALL abort an active sweep.
REQ-007 iMode  input  1  SHALL select the sweep type, sampled with iStart: 0 = single sweep, 1 = continuous.
REQ-008 iMask  input  4  SHALL enable channels 0..3, one bit per channel, latched when iStart is accepted.
REQ-009 iZ  input  WIDTH  SHALL carry the data returned from the 4:1 selector output.
REQ-010 oS0, oS1  output  1 each  SHALL drive the selector select lines; channel = {oS1,oS0}.
REQ-011 oData  output  WIDTH  SHALL hold the last captured sample.
REQ-012 oChan  output  2  SHALL give the channel index of oData.
REQ-013 oValid  output  1  SHALL pulse for one cycle per captured sample.
REQ-014 oBusy  output  1  SHALL be high whenever the state is not IDLE.
REQ-015 oDone  output  1  SHALL pulse for one cycle when a single sweep completes.

Function
REQ-016 The FSM SHALL have three states: IDLE, SETTLE, CAPTURE.
REQ-017 IDLE -> SETTLE: iStart=1, iMask!=0 and iStop=0 SHALL latch iMask and iMode, select the lowest enabled channel and clear the dwell counter.
REQ-018 In IDLE with iStart=1 and iMask=0, the block SHALL ignore the request: no state change and no oDone.
REQ-019 SETTLE SHALL last exactly DWELL cycles with the current channel on oS1/oS0; on the edge ending the last SETTLE cycle, oData<=iZ, oChan<=channel and the state SHALL go to CAPTURE.
REQ-020 CAPTURE SHALL last one cycle with oValid=1; oS1/oS0 SHALL be held unchanged.
REQ-021 From CAPTURE, the block SHALL advance to the next enabled channel in ascending order and return to SETTLE with the counter cleared.
REQ-022 When advancing past the highest enabled channel in single mode, the block SHALL return to IDLE and pulse oDone in the first IDLE cycle.
REQ-023 When advancing past the highest enabled channel in continuous mode, the block SHALL wrap to the lowest enabled channel without an oDone pulse.
REQ-024 Per-channel period SHALL be DWELL+1 cycles; with start accepted at edge k, the first oValid SHALL occur in cycle k+1+DWELL.
REQ-025 iStop=1 in SETTLE or CAPTURE SHALL force IDLE at the next edge, with no further oValid and no oDone; iStop has priority over all other transitions.
REQ-026 iStart while busy, and iMask or iMode changes while busy, SHALL be ignored.
REQ-027 With a single enabled channel, the block SHALL repeatedly capture that channel (continuous mode) or capture it once (single mode).
REQ-028 oS1/oS0 in IDLE SHALL hold the last channel used; oData and oChan SHALL hold their last values until the next capture.

Reset
REQ-029 iRst=1 SHALL immediately force: state IDLE, oS0=oS1=0, oData=0, oChan=0, oValid=0, oBusy=0, oDone=0, dwell counter 0, latched mask 0.
REQ-030 Reset asserted mid-sweep SHALL discard the sweep; no oValid or oDone SHALL follow reset release.

Structure
REQ-031 A shared package scan_pkg SHALL hold the state enum (IDLE, SETTLE, CAPTURE), the channel-count constant (4) and the DWELL default.
REQ-032 Next-channel selection SHALL be one combinational sub-module, scan_next_chan: inputs are the current channel and the latched mask; outputs are the next channel and a wrap flag.
REQ-033 channel_scanner SHALL connect directly to the 4:1 selector via oS0/oS1 -> select lines and selector output -> iZ.

Verification
REQ-034 Single sweep: DWELL=4, mask 1111, selector data 0001/0010/0100/1000; start at edge 0 -> oValid in cycles 5, 10, 15, 20 with oData 0001, 0010, 0100, 1000, oChan 0..3, and oDone in cycle 21.
REQ-035 Sparse mask: mask 1010, single mode -> captures only channels 1 and 3 (data 0010, 1000), then oDone; oS never selects channel 0 or 2.
REQ-036 Continuous mode: mask 1001 -> capture sequence 0, 3, 0, 3 ... with no oDone; iStop in the middle of a SETTLE cycle -> IDLE next cycle and no oValid afterwards.
REQ-037 Boundaries: iStart with mask 0000 -> oBusy stays 0; iStart pulsed while busy -> sweep timing unchanged.
REQ-038 Reset: iRst asserted between clock edges during CAPTURE -> all outputs 0 immediately; after release, no oValid or oDone until a new iStart.
